// File: rtl/iob_wb_sim_mem.sv
// Wishbone B3 slave memory model for the ethmac DMA bench: wait states, cti/bte
// bursts with per-beat range checking, and an error response past the end of storage.
module iob_wb_sim_mem #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_ADDR_W  = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  localparam int AW    = ADDR_W - 2;
  localparam int IDX_W = MEM_ADDR_W - 2;
  localparam int WORDS = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] BYTE_LIM  = ADDR_W'(1) << MEM_ADDR_W;
  localparam logic [AW-1:0]     WORD_LIM  = AW'(1) << IDX_W;
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_BURST = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem_r [WORDS];
  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [AW-1:0]     addr_r;
  logic              ack_r;
  logic              err_r;

  logic [ADDR_W-1:0] offset_s;
  logic              req_oor_s;
  logic [AW-1:0]     next_s;
  logic              next_oor_s;

  // Wrap-N bursts only step the low log2(N) word-address bits.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [AW-1:0] n;
    n = a;
    case (bte)
      2'b00:   n      = a + AW'(1);
      2'b01:   n[1:0] = a[1:0] + 2'd1;
      2'b10:   n[2:0] = a[2:0] + 3'd1;
      2'b11:   n[3:0] = a[3:0] + 4'd1;
      default: n      = a + AW'(1);
    endcase
    return n;
  endfunction

  assign offset_s   = wb_adr_i - BASE_ADDR;
  assign req_oor_s  = (offset_s >= BYTE_LIM);
  assign next_s     = next_addr(addr_r, wb_bte_i);
  assign next_oor_s = (next_s >= WORD_LIM);

  // ack_r/err_r mean "this beat is ready"; they are only shown while the master strobes.
  assign wb_ack_o = ack_r & wb_cyc_i & wb_stb_i;
  assign wb_err_o = err_r & wb_cyc_i & wb_stb_i;
  assign wb_dat_o = mem_r[addr_r[IDX_W-1:0]];

  // Transfer sequencing: request latch, wait states, response and burst beats
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= {AW{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else if (!wb_cyc_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wb_stb_i) begin
            addr_r <= offset_s[ADDR_W-1:2];
            if (WAIT_CYCLES == 0) begin
              state_r <= ST_RESP;
              ack_r   <= ~req_oor_s;
              err_r   <= req_oor_s;
            end else begin
              cnt_r   <= WAIT_INIT;
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r <= 4'd1) begin
            state_r <= ST_RESP;
            ack_r   <= ~req_oor_s;
            err_r   <= req_oor_s;
          end
        end
        ST_RESP, ST_BURST: begin
          if (wb_stb_i) begin
            if (err_r || (wb_cti_i != 3'b010)) begin
              state_r <= ST_IDLE;
              ack_r   <= 1'b0;
              err_r   <= 1'b0;
            end else begin
              addr_r  <= next_s;
              state_r <= ST_BURST;
              ack_r   <= ~next_oor_s;
              err_r   <= next_oor_s;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane write on the edge that closes an acknowledged write beat
  always_ff @(posedge wb_clk_i) begin
    if (wb_ack_o && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem_r[addr_r[IDX_W-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_wb_sim_mem.sv
// Self-checking bench for iob_wb_sim_mem: vector table, hand sequences for bursts,
// abort and reset, then random traffic against a word-array reference model.
module tb_iob_wb_sim_mem;

  localparam int WAIT_CYCLES = 2;
  localparam int MEM_ADDR_W  = 14;
  localparam int WORDS       = 1 << (MEM_ADDR_W - 2);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  logic [31:0] ref_mem   [WORDS];
  bit          ref_known [WORDS];
  logic [31:0] bdat      [16];

  iob_wb_sim_mem #(
    .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(MEM_ADDR_W),
    .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_sel_i(sel),
    .wb_we_i(we), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_cyc_i(cyc),
    .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte), .wb_ack_o(ack), .wb_err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_peek(input int w);
    return dut.mem_r[w];
  endfunction

  task automatic ref_write(input int w, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    if (s == 4'hF) ref_known[w] = 1'b1;
  endtask

  // Word touched by beat k of a burst starting at word s
  function automatic int exp_word(input int s, input int b, input int k);
    int n;
    n = (b == 0) ? 0 : (b == 1) ? 4 : (b == 2) ? 8 : 16;
    if (n == 0) return s + k;
    return (s / n) * n + ((s % n) + k) % n;
  endfunction

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; cti = 3'b000; bte = 2'b00;
    adr = 32'h0; dat_w = 32'h0;
  endtask

  task automatic classic(input logic [31:0] a, input bit w, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd,
                         output bit ak, output bit er, output int lat);
    @(posedge clk); #1;
    adr = a; we = w; sel = s; dat_w = d; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    ak = 1'b0; er = 1'b0; rd = 32'h0; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack || err) begin
        ak = ack; er = err; rd = dat_r; lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic do_classic(input string name, input logic [31:0] a, input bit w,
                            input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    bit ak, er, oor;
    int lat, wd;
    oor = (a >= 32'h0000_4000);
    wd  = int'(a[13:2]);
    classic(a, w, s, d, rd, ak, er, lat);
    check({name, " err"}, 32'(er), 32'(oor));
    check({name, " ack"}, 32'(ak), 32'(!oor));
    check({name, " latency"}, lat, WAIT_CYCLES + 1);
    if (!oor) begin
      if (w) ref_write(wd, s, d);
      else if (ref_known[wd]) check({name, " data"}, rd, ref_mem[wd]);
    end
  endtask

  task automatic burst(input logic [31:0] a, input bit w, input logic [1:0] b, input int n,
                       input int gap_at, output int n_ack, output int n_err,
                       output int bad_gap, output int gap_acks);
    int  prev;
    bit  got, was_err;
    n_ack = 0; n_err = 0; bad_gap = 0; gap_acks = 0; prev = 0;
    @(posedge clk); #1;
    adr = a; we = w; bte = b; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < n; k++) begin
      cti   = (k == n - 1) ? 3'b111 : 3'b010;
      dat_w = bdat[k];
      if (k > 0) adr = $urandom;
      if (k == gap_at) begin
        stb = 1'b0;
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          if (ack || err) gap_acks++;
          @(posedge clk); #1;
        end
        stb = 1'b1;
      end
      got = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (ack || err) begin got = 1'b1; break; end
      end
      if (!got) break;
      if (!w) bdat[k] = dat_r;
      if (ack) n_ack++;
      if (err) n_err++;
      was_err = err;
      if (k > 0 && cyc_no != prev + ((k == gap_at) ? 3 : 1)) bad_gap++;
      prev = cyc_no;
      @(posedge clk); #1;
      if (was_err) break;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  task automatic do_burst(input string name, input int s, input bit w, input logic [1:0] b,
                          input int n, input int gap_at);
    int na, ne, bg, ga, wd;
    if (w) for (int k = 0; k < n; k++) bdat[k] = $urandom;
    burst(32'(s * 4), w, b, n, gap_at, na, ne, bg, ga);
    check({name, " acks"}, na, n);
    check({name, " errs"}, ne, 0);
    check({name, " beat spacing"}, bg, 0);
    if (gap_at >= 0) check({name, " acks in gap"}, ga, 0);
    for (int k = 0; k < na; k++) begin
      wd = exp_word(s, int'(b), k);
      if (w) ref_write(wd, 4'hF, bdat[k]);
      else if (ref_known[wd]) check({name, " data"}, bdat[k], ref_mem[wd]);
    end
  endtask

  task automatic mem_load(input int w, input logic [31:0] d);
    do_classic("mem_load", 32'(w * 4), 1'b1, 4'hF, d);
  endtask

  typedef struct {
    logic [31:0] a;
    bit          w;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  initial begin
    vec_t        vecs [14];
    logic [31:0] rd;
    bit          ak, er, got;
    int          lat, cnt, r, nb, sw, gp;
    logic [31:0] a;

    vecs[0]  = '{32'h0000_0000, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h0,          1'b0};
    vecs[1]  = '{32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[2]  = '{32'h0000_0010, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF,  1'b0};
    vecs[3]  = '{32'h0000_0010, 1'b1, 4'h1, 32'h0000_00AA, 32'h0,          1'b0};
    vecs[4]  = '{32'h0000_0010, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEAA,  1'b0};
    vecs[5]  = '{32'h0000_0014, 1'b1, 4'hF, 32'h1122_3344, 32'h0,          1'b0};
    vecs[6]  = '{32'h0000_0014, 1'b1, 4'hA, 32'hAABB_CCDD, 32'h0,          1'b0};
    vecs[7]  = '{32'h0000_0014, 1'b0, 4'hF, 32'h0,         32'hAA22_CC44,  1'b0};
    vecs[8]  = '{32'h0000_3FFC, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0,          1'b0};
    vecs[9]  = '{32'h0000_3FFC, 1'b0, 4'hF, 32'h0,         32'hCAFE_F00D,  1'b0};
    vecs[10] = '{32'h0000_4000, 1'b0, 4'hF, 32'h0,         32'h0,          1'b1};
    vecs[11] = '{32'h0000_4000, 1'b1, 4'hF, 32'h5555_AAAA, 32'h0,          1'b1};
    vecs[12] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,         32'h0BAD_F00D,  1'b0};
    vecs[13] = '{32'h0000_0013, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEAA,  1'b0};

    for (int i = 0; i < WORDS; i++) begin ref_mem[i] = 32'h0; ref_known[i] = 1'b0; end
    bus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset ack", 32'(ack), 32'h0);
    check("reset err", 32'(err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      classic(vecs[i].a, vecs[i].w, vecs[i].s, vecs[i].d, rd, ak, er, lat);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d ack", i), 32'(ak), 32'(!vecs[i].exp_err));
      check($sformatf("vec%0d latency", i), lat, WAIT_CYCLES + 1);
      if (!vecs[i].w && !vecs[i].exp_err) check($sformatf("vec%0d data", i), rd, vecs[i].exp_rd);
      if (vecs[i].w && !vecs[i].exp_err) ref_write(int'(vecs[i].a[13:2]), vecs[i].s, vecs[i].d);
    end

    // Linear read burst of four, then a classic cycle must see full latency again
    for (int i = 0; i < 4; i++) mem_load(32'h40 + i, 32'(i + 1));
    do_burst("linear rd", 32'h40, 1'b0, 2'b00, 4, -1);
    for (int k = 0; k < 4; k++) check("linear rd value", bdat[k], 32'(k + 1));
    do_classic("after burst", 32'h0000_0100, 1'b0, 4'hF, 32'h0);

    // Wrap4 read from word 6
    for (int i = 4; i < 8; i++) mem_load(i, 32'hA0 + 32'(i));
    do_burst("wrap4 rd", 6, 1'b0, 2'b01, 4, -1);
    check("wrap4 beat0", bdat[0], 32'hA6);
    check("wrap4 beat1", bdat[1], 32'hA7);
    check("wrap4 beat2", bdat[2], 32'hA4);
    check("wrap4 beat3", bdat[3], 32'hA5);

    // Write burst with a two-cycle master wait before the third beat
    mem_load(32'h84, 32'h7777_0084);
    do_burst("gap wr", 32'h80, 1'b1, 2'b00, 4, 2);
    for (int k = 0; k < 4; k++) check("gap wr word", mem_peek(32'h80 + k), bdat[k]);
    check("gap wr untouched", mem_peek(32'h84), 32'h7777_0084);

    // Abort during wait states
    mem_load(32'h30, 32'h1357_9BDF);
    @(posedge clk); #1;
    adr = 32'hC0; we = 1'b1; sel = 4'hF; dat_w = 32'hFFFF_FFFF; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (ack || err) cnt++; end
    check("abort acks", cnt, 0);
    check("abort mem", mem_peek(32'h30), 32'h1357_9BDF);
    do_classic("after abort", 32'h0000_00C0, 1'b0, 4'hF, 32'h0);

    // Reset during wait states of a write
    mem_load(32'h34, 32'h2468_ACE0);
    @(posedge clk); #1;
    adr = 32'hD0; we = 1'b1; sel = 4'hF; dat_w = 32'h0; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst in wait ack", 32'(ack | err), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1 rst = 1'b0;
    check("rst in wait mem", mem_peek(32'h34), 32'h2468_ACE0);
    do_classic("after rst", 32'h0000_00D0, 1'b0, 4'hF, 32'h0);

    // Reset mid-ack must drop ack at once
    @(posedge clk); #1;
    adr = 32'hD0; we = 1'b0; sel = 4'hF; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin @(negedge clk); if (ack) begin got = 1'b1; break; end end
    check("pre-rst ack seen", 32'(got), 32'h1);
    #1 rst = 1'b1;
    #1 check("async rst drops ack", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Random traffic over words 0..63 after filling them with bursts
    for (int i = 0; i < 4; i++) do_burst("fill", i * 16, 1'b1, 2'b00, 16, -1);
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        do_classic("rand classic", a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
      end else if (r < 7) begin
        do_classic("rand oor", $urandom | 32'h0000_4000, 1'($urandom_range(0, 1)), 4'hF, $urandom);
      end else begin
        nb = $urandom_range(1, 6);
        sw = $urandom_range(0, 57);
        gp = (nb > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, nb - 1) : -1;
        do_burst("rand burst", sw, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), nb, gp);
      end
    end

    cnt = 0;
    for (int i = 0; i < WORDS; i++) if (ref_known[i] && mem_peek(i) !== ref_mem[i]) cnt++;
    check("final memory image mismatched words", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
